// File: rtl/ds_operand_stage_pkg.sv
// Shared defaults and forward-bus layout for the decode-stage operand unit.
package ds_operand_stage_pkg;

    // Default datapath geometry.
    localparam int unsigned DS_XLEN = 32;
    localparam int unsigned DS_AW   = 5;
    localparam int unsigned DS_NRD  = 2;
    localparam int unsigned DS_NFWD = 3;
    localparam int unsigned DS_PW   = 64;
    localparam int unsigned DS_CNTW = 32;

    // Forward-source ordering: lower index is younger and wins on a tie.
    localparam int unsigned FWD_EXE = 0;
    localparam int unsigned FWD_MEM = 1;
    localparam int unsigned FWD_WB  = 2;

    // One forward source with default geometry, packed {we, dest, ready, data}.
    typedef struct packed {
        logic                 we;
        logic [DS_AW-1:0]     dest;
        logic                 ready;
        logic [DS_XLEN-1:0]   data;
    } fwd_src_t;

    // Width of one packed forward source with default geometry.
    localparam int unsigned FWD_SRC_W = 1 + DS_AW + 1 + DS_XLEN;

endpackage

// File: rtl/ds_fwd_mux.sv
// Per-read-port operand resolution: priority search over the forward sources,
// falling back to the regfile, plus the port's load-use hazard bit.
module ds_fwd_mux
    import ds_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = DS_XLEN,
    parameter int unsigned AW   = DS_AW,
    parameter int unsigned NFWD = DS_NFWD
) (
    input  logic [AW-1:0]        raddr,
    input  logic                 rused,
    input  logic [XLEN-1:0]      rf_rdata,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*AW-1:0]   fwd_dest,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]      rdata,
    output logic                 hazard
);

    logic            hit;
    logic            sel_ready;
    logic [XLEN-1:0] sel_data;
    logic            raddr_nz;

    assign raddr_nz = |raddr;

    // Lowest-index (youngest) matching source wins; r0 never matches.
    always_comb begin
        hit       = 1'b0;
        sel_ready = 1'b1;
        sel_data  = rf_rdata;
        for (int unsigned k = 0; k < NFWD; k++) begin
            if (!hit && raddr_nz && fwd_we[k] && (fwd_dest[k*AW +: AW] == raddr)) begin
                hit       = 1'b1;
                sel_ready = fwd_ready[k];
                sel_data  = fwd_data[k*XLEN +: XLEN];
            end
        end
    end

    // Operand value and stall request; an older not-ready source behind a
    // younger match is invisible here by construction.
    always_comb begin
        rdata  = raddr_nz ? sel_data : '0;
        hazard = rused & hit & ~sel_ready;
    end

endmodule

// File: rtl/ds_operand_stage.sv
// Decode-stage operand unit: FS->DS pipeline register with valid/allowin
// handshake and flush, per-port forward resolution, and a saturating
// stall-cycle counter.
module ds_operand_stage
    import ds_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = DS_XLEN,
    parameter int unsigned AW   = DS_AW,
    parameter int unsigned NRD  = DS_NRD,
    parameter int unsigned NFWD = DS_NFWD,
    parameter int unsigned PW   = DS_PW,
    parameter int unsigned CNTW = DS_CNTW
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,

    input  logic                 fs2ds_valid,
    output logic                 ds_allowin,
    input  logic [XLEN-1:0]      fs_pc,
    input  logic [NRD*AW-1:0]    fs_raddr,
    input  logic [NRD-1:0]       fs_rused,
    input  logic [PW-1:0]        fs_payload,

    output logic                 ds2es_valid,
    input  logic                 es_allowin,
    output logic [XLEN-1:0]      ds_pc,
    output logic [PW-1:0]        ds_payload,
    output logic [NRD*XLEN-1:0]  ds_rdata,

    output logic [NRD*AW-1:0]    rf_raddr,
    input  logic [NRD*XLEN-1:0]  rf_rdata,

    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*AW-1:0]   fwd_dest,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*XLEN-1:0] fwd_data,

    input  logic                 stall_cnt_clr,
    output logic [CNTW-1:0]      stall_cnt
);

    localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

    logic              ds_valid_q, ds_valid_d;
    logic [XLEN-1:0]   pc_q;
    logic [PW-1:0]     payload_q;
    logic [NRD*AW-1:0] raddr_q;
    logic [NRD-1:0]    rused_q;
    logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;

    logic [NRD-1:0]    hazard;
    logic              ds_ready_go;
    logic              load_en;

    // One resolver per read port, all working off the held register numbers.
    for (genvar i = 0; i < NRD; i++) begin : g_port
        ds_fwd_mux #(
            .XLEN (XLEN),
            .AW   (AW),
            .NFWD (NFWD)
        ) u_fwd_mux (
            .raddr     (raddr_q[i*AW +: AW]),
            .rused     (rused_q[i]),
            .rf_rdata  (rf_rdata[i*XLEN +: XLEN]),
            .fwd_we    (fwd_we),
            .fwd_dest  (fwd_dest),
            .fwd_ready (fwd_ready),
            .fwd_data  (fwd_data),
            .rdata     (ds_rdata[i*XLEN +: XLEN]),
            .hazard    (hazard[i])
        );
    end

    // Handshake: hold while any consumed operand waits on its producer.
    always_comb begin
        ds_ready_go = ~|hazard;
        ds_allowin  = ~ds_valid_q | (ds_ready_go & es_allowin);
        ds2es_valid = ds_valid_q & ds_ready_go;
        load_en     = fs2ds_valid & ds_allowin;
    end

    // Next valid: flush beats a simultaneous accept.
    always_comb begin
        ds_valid_d = ds_valid_q;
        if (flush) begin
            ds_valid_d = 1'b0;
        end else if (ds_allowin) begin
            ds_valid_d = fs2ds_valid;
        end
    end

    // Stall counter next state: clear wins, then saturating increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (ds_valid_q && !ds_ready_go && !flush && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
    end

    // Valid bit and stall counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Held instruction fields; only an accepted transfer updates them, so a
    // flush leaves them as they were.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q      <= '0;
            payload_q <= '0;
            raddr_q   <= '0;
            rused_q   <= '0;
        end else if (load_en) begin
            pc_q      <= fs_pc;
            payload_q <= fs_payload;
            raddr_q   <= fs_raddr;
            rused_q   <= fs_rused;
        end
    end

    assign ds_pc      = pc_q;
    assign ds_payload = payload_q;
    assign rf_raddr   = raddr_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ds_operand_stage.sv
// Self-checking bench for ds_operand_stage: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_ds_operand_stage;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NFWD = 3;
    localparam int PW   = 64;
    localparam int CNTW = 4;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 flush;
    logic                 fs2ds_valid;
    logic                 ds_allowin;
    logic [XLEN-1:0]      fs_pc;
    logic [NRD*AW-1:0]    fs_raddr;
    logic [NRD-1:0]       fs_rused;
    logic [PW-1:0]        fs_payload;
    logic                 ds2es_valid;
    logic                 es_allowin;
    logic [XLEN-1:0]      ds_pc;
    logic [PW-1:0]        ds_payload;
    logic [NRD*XLEN-1:0]  ds_rdata;
    logic [NRD*AW-1:0]    rf_raddr;
    logic [NRD*XLEN-1:0]  rf_rdata;
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD*AW-1:0]   fwd_dest;
    logic [NFWD-1:0]      fwd_ready;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 stall_cnt_clr;
    logic [CNTW-1:0]      stall_cnt;

    // Forward sources as the bench sees them: 0=EXE, 1=MEM, 2=WB.
    logic            src_we[NFWD];
    logic [AW-1:0]   src_dest[NFWD];
    logic            src_ready[NFWD];
    logic [XLEN-1:0] src_data[NFWD];
    logic [XLEN-1:0] rf[32];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic            m_valid;
    logic [XLEN-1:0] m_pc;
    logic [PW-1:0]   m_payload;
    logic [AW-1:0]   m_raddr[NRD];
    logic            m_rused[NRD];
    int              m_cnt;
    logic [XLEN-1:0] m_rdata[NRD];
    logic            m_go, m_ds2es, m_allowin;

    ds_operand_stage #(
        .XLEN (XLEN), .AW (AW), .NRD (NRD), .NFWD (NFWD), .PW (PW), .CNTW (CNTW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush         (flush),
        .fs2ds_valid   (fs2ds_valid),
        .ds_allowin    (ds_allowin),
        .fs_pc         (fs_pc),
        .fs_raddr      (fs_raddr),
        .fs_rused      (fs_rused),
        .fs_payload    (fs_payload),
        .ds2es_valid   (ds2es_valid),
        .es_allowin    (es_allowin),
        .ds_pc         (ds_pc),
        .ds_payload    (ds_payload),
        .ds_rdata      (ds_rdata),
        .rf_raddr      (rf_raddr),
        .rf_rdata      (rf_rdata),
        .fwd_we        (fwd_we),
        .fwd_dest      (fwd_dest),
        .fwd_ready     (fwd_ready),
        .fwd_data      (fwd_data),
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cnt     (stall_cnt)
    );

    initial forever #5 clk = ~clk;

    // Bench regfile answers whatever address the stage presents.
    assign rf_rdata = {rf[rf_raddr[9:5]], rf[rf_raddr[4:0]]};

    always_comb begin
        fwd_we = '0; fwd_dest = '0; fwd_ready = '0; fwd_data = '0;
        for (int k = 0; k < NFWD; k++) begin
            fwd_we[k]                = src_we[k];
            fwd_dest[k*AW +: AW]     = src_dest[k];
            fwd_ready[k]             = src_ready[k];
            fwd_data[k*XLEN +: XLEN] = src_data[k];
        end
    end

    // Combinational expectations: youngest writer of the register wins.
    task automatic model_eval();
        m_go = 1'b1;
        for (int i = 0; i < NRD; i++) begin
            int win = -1;
            for (int k = 0; k < NFWD; k++) begin
                if (src_we[k] && src_dest[k] == m_raddr[i] && m_raddr[i] != 0) begin
                    win = k;
                    break;
                end
            end
            if (m_raddr[i] == 0)  m_rdata[i] = '0;
            else if (win >= 0)    m_rdata[i] = src_data[win];
            else                  m_rdata[i] = rf[m_raddr[i]];
            if (m_rused[i] && win >= 0 && !src_ready[win]) m_go = 1'b0;
        end
        m_ds2es   = m_valid && m_go;
        m_allowin = !m_valid || (m_go && es_allowin);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_payload = '0; m_cnt = 0;
        for (int i = 0; i < NRD; i++) begin
            m_raddr[i] = '0; m_rused[i] = 1'b0;
        end
    endtask

    // Advance model and DUT one clock; returns 1 ns after the edge.
    task automatic step();
        logic accept;
        int   cnt_n;
        model_eval();
        accept = fs2ds_valid && m_allowin;
        cnt_n  = m_cnt;
        if (stall_cnt_clr) cnt_n = 0;
        else if (m_valid && !m_go && !flush && m_cnt < (1 << CNTW) - 1) cnt_n = m_cnt + 1;
        @(posedge clk);
        m_cnt = cnt_n;
        if (flush)          m_valid = 1'b0;
        else if (m_allowin) m_valid = fs2ds_valid;
        if (accept) begin
            m_pc = fs_pc; m_payload = fs_payload;
            for (int i = 0; i < NRD; i++) begin
                m_raddr[i] = fs_raddr[i*AW +: AW];
                m_rused[i] = fs_rused[i];
            end
        end
        #1;
    endtask

    task automatic clear_fwd();
        for (int k = 0; k < NFWD; k++) begin
            src_we[k] = 1'b0; src_dest[k] = '0; src_ready[k] = 1'b1; src_data[k] = '0;
        end
    endtask

    task automatic set_src(input int k, input logic [AW-1:0] d, input logic rdy,
                           input logic [XLEN-1:0] v);
        src_we[k] = 1'b1; src_dest[k] = d; src_ready[k] = rdy; src_data[k] = v;
    endtask

    // Empty the stage and zero the counter.
    task automatic drain();
        clear_fwd(); flush = 1'b0; fs2ds_valid = 1'b0; es_allowin = 1'b1;
        stall_cnt_clr = 1'b1;
        step(); step();
        stall_cnt_clr = 1'b0;
    endtask

    task automatic load_instr(input logic [XLEN-1:0] pc, input logic [AW-1:0] ra0,
                              input logic [AW-1:0] ra1, input logic [NRD-1:0] ru);
        fs2ds_valid = 1'b1; fs_pc = pc; fs_raddr = {ra1, ra0}; fs_rused = ru;
        fs_payload = {$urandom, $urandom};
        step();
        fs2ds_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        n_checks++;
        if (ds2es_valid !== 1'b0 || ds_allowin !== 1'b1 || stall_cnt !== 4'd0 || ds_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: ds2es_valid=%b allowin=%b cnt=%0d pc=%h, want 0 1 0 0",
                     ds2es_valid, ds_allowin, stall_cnt, ds_pc);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        #1;
        // Build a stalled, counted instruction, then reset mid-cycle.
        load_instr(32'h100, 5'd5, 5'd0, 2'b01);
        set_src(0, 5'd5, 1'b0, 32'h1);
        step(); step();
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (ds2es_valid !== 1'b0 || ds_allowin !== 1'b1 || stall_cnt !== 4'd0 ||
            ds_pc !== '0 || ds_payload !== '0 || rf_raddr !== '0) begin
            n_fail++;
            $display("FAIL reset_async: ds2es_valid=%b allowin=%b cnt=%0d pc=%h raddr=%h, want 0 1 0 0 0",
                     ds2es_valid, ds_allowin, stall_cnt, ds_pc, rf_raddr);
        end
        model_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        clear_fwd();
        #1;
    endtask

    task automatic test_priority();
        drain();
        load_instr(32'h200, 5'd5, 5'd3, 2'b11);
        set_src(0, 5'd5, 1'b1, 32'h11);
        set_src(1, 5'd5, 1'b1, 32'h22);
        #1;
        n_checks++;
        if (ds_rdata[31:0] !== 32'h11 || ds2es_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL priority: rdata0=%h ds2es_valid=%b, want 00000011 1",
                     ds_rdata[31:0], ds2es_valid);
        end
        n_checks++;
        if (ds_rdata[63:32] !== rf[3] || rf_raddr !== {5'd3, 5'd5}) begin
            n_fail++;
            $display("FAIL priority_rf: rdata1=%h rf_raddr=%h, want %h %h",
                     ds_rdata[63:32], rf_raddr, rf[3], {5'd3, 5'd5});
        end
    endtask

    task automatic test_load_use();
        drain();
        load_instr(32'h300, 5'd5, 5'd0, 2'b01);
        set_src(0, 5'd5, 1'b0, 32'hDEAD);
        #1;
        n_checks++;
        if (ds2es_valid !== 1'b0 || ds_allowin !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_stall: ds2es_valid=%b allowin=%b, want 0 0",
                     ds2es_valid, ds_allowin);
        end
        step();
        clear_fwd();
        set_src(2, 5'd5, 1'b1, 32'hAB);
        #1;
        n_checks++;
        if (stall_cnt !== 4'd1 || ds2es_valid !== 1'b1 || ds_rdata[31:0] !== 32'hAB ||
            ds_pc !== 32'h300) begin
            n_fail++;
            $display("FAIL load_use_fwd: cnt=%0d ds2es_valid=%b rdata0=%h pc=%h, want 1 1 000000ab 300",
                     stall_cnt, ds2es_valid, ds_rdata[31:0], ds_pc);
        end
    endtask

    task automatic test_mask_r0();
        drain();
        load_instr(32'h400, 5'd7, 5'd0, 2'b11);
        set_src(0, 5'd7, 1'b1, 32'h77);
        set_src(1, 5'd7, 1'b0, 32'h88);
        set_src(2, 5'd0, 1'b0, 32'h99);
        #1;
        n_checks++;
        if (ds2es_valid !== 1'b1 || ds_rdata[31:0] !== 32'h77) begin
            n_fail++;
            $display("FAIL mask_younger: ds2es_valid=%b rdata0=%h, want 1 00000077",
                     ds2es_valid, ds_rdata[31:0]);
        end
        n_checks++;
        if (ds_rdata[63:32] !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_zero: rdata1=%h, want 0", ds_rdata[63:32]);
        end
        drain();
        load_instr(32'h410, 5'd1, 5'd9, 2'b01);
        set_src(0, 5'd9, 1'b0, 32'h5);
        #1;
        n_checks++;
        if (ds2es_valid !== 1'b1 || ds_rdata[31:0] !== rf[1]) begin
            n_fail++;
            $display("FAIL rused0_nostall: ds2es_valid=%b rdata0=%h, want 1 %h",
                     ds2es_valid, ds_rdata[31:0], rf[1]);
        end
    endtask

    task automatic test_flush();
        drain();
        load_instr(32'h500, 5'd4, 5'd0, 2'b01);
        set_src(0, 5'd4, 1'b0, 32'h1);
        step();
        flush = 1'b1; fs2ds_valid = 1'b1; fs_pc = 32'h5A5;
        #1;
        n_checks++;
        if (ds_allowin !== 1'b0 || stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL flush_pre: allowin=%b cnt=%0d, want 0 1", ds_allowin, stall_cnt);
        end
        step();
        flush = 1'b0; fs2ds_valid = 1'b0;
        #1;
        n_checks++;
        if (ds2es_valid !== 1'b0 || ds_allowin !== 1'b1 || stall_cnt !== 4'd1 ||
            ds_pc !== 32'h500) begin
            n_fail++;
            $display("FAIL flush_drop: ds2es_valid=%b allowin=%b cnt=%0d pc=%h, want 0 1 1 500",
                     ds2es_valid, ds_allowin, stall_cnt, ds_pc);
        end
    endtask

    task automatic test_saturation();
        drain();
        load_instr(32'h600, 5'd6, 5'd0, 2'b01);
        set_src(1, 5'd6, 1'b0, 32'h1);
        for (int c = 0; c < 20; c++) step();
        n_checks++;
        if (stall_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL saturate: cnt=%0d, want 15", stall_cnt);
        end
        stall_cnt_clr = 1'b1;
        step();
        stall_cnt_clr = 1'b0;
        n_checks++;
        if (stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL clr: cnt=%0d, want 0", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        for (int n = 0; n < 4; n++) begin
            fs2ds_valid = 1'b1; fs_pc = 32'h700 + 4 * n; fs_raddr = '0; fs_rused = '0;
            fs_payload = {$urandom, $urandom};
            step();
            n_checks++;
            if (ds2es_valid !== 1'b1 || ds_allowin !== 1'b1 || ds_pc !== 32'h700 + 4 * n) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: ds2es_valid=%b allowin=%b pc=%h, want 1 1 %h",
                         n, ds2es_valid, ds_allowin, ds_pc, 32'h700 + 4 * n);
            end
        end
        fs2ds_valid = 1'b0;
    endtask

    task automatic test_random();
        drain();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NFWD; k++) begin
                src_we[k]    = ($urandom_range(0, 3) != 0);
                src_dest[k]  = AW'($urandom_range(0, 7));
                src_ready[k] = ($urandom_range(0, 3) != 0);
                src_data[k]  = $urandom;
            end
            fs2ds_valid   = ($urandom_range(0, 2) != 0);
            fs_pc         = $urandom;
            fs_raddr      = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            fs_rused      = NRD'($urandom_range(0, 3));
            fs_payload    = {$urandom, $urandom};
            es_allowin    = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            stall_cnt_clr = ($urandom_range(0, 31) == 0);
            #1;
            model_eval();
            n_checks++;
            if (ds2es_valid !== m_ds2es || ds_allowin !== m_allowin ||
                stall_cnt !== CNTW'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: ds2es=%b allowin=%b cnt=%0d, want %b %b %0d",
                         c, ds2es_valid, ds_allowin, stall_cnt, m_ds2es, m_allowin, m_cnt);
            end
            if (m_valid) begin
                n_checks++;
                if (ds_pc !== m_pc || ds_payload !== m_payload ||
                    ds_rdata !== {m_rdata[1], m_rdata[0]}) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: pc=%h rdata=%h, want %h %h",
                             c, ds_pc, ds_rdata, m_pc, {m_rdata[1], m_rdata[0]});
                end
            end
            step();
        end
        flush = 1'b0; stall_cnt_clr = 1'b0;
    endtask

    initial begin
        flush = 1'b0; fs2ds_valid = 1'b0; es_allowin = 1'b1; stall_cnt_clr = 1'b0;
        fs_pc = '0; fs_raddr = '0; fs_rused = '0; fs_payload = '0;
        for (int r = 0; r < 32; r++) rf[r] = $urandom | 32'h1;
        clear_fwd();
        model_reset();
        test_reset();
        test_priority();
        test_load_use();
        test_mask_r0();
        test_flush();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
